// File: rtl/child_launch_sequencer.sv
// child_launch_sequencer: starts the enabled children one at a time, lowest index first.
// After each start it waits for that child's done, subject to a per-child timeout.
// It reports busy/done/error upward. All outputs are registered and change with the FSM.
module child_launch_sequencer #(
    parameter int NUM_CHILD      = 5,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int IDX_W          = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic                 abort,
    input  logic [NUM_CHILD-1:0] enable_mask,
    output logic [NUM_CHILD-1:0] child_start,
    input  logic [NUM_CHILD-1:0] child_done,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [IDX_W-1:0]     err_idx,
    output logic [IDX_W-1:0]     active_idx
);

    // The timer counts 0..TIMEOUT_CYCLES-1. WAIT exits at the limit, so the timer never wraps.
    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_t;

    state_t               state;
    logic [NUM_CHILD-1:0] mask_q;
    logic [NUM_CHILD-1:0] mask_rem;
    logic [TMR_W-1:0]     timer;

    function automatic logic [IDX_W-1:0] lowest(input logic [NUM_CHILD-1:0] m);
        lowest = '0;
        for (int i = NUM_CHILD - 1; i >= 0; i--)
            if (m[i]) lowest = IDX_W'(i);
    endfunction

    function automatic logic [NUM_CHILD-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Children still pending once the active child has finished
    always_comb begin
        mask_rem = mask_q & ~onehot(active_idx);
    end

    // Sequencer FSM; each output register is loaded together with the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mask_q      <= '0;
            timer       <= '0;
            child_start <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_idx     <= '0;
            active_idx  <= '0;
        end else begin
            child_start <= '0;
            done        <= 1'b0;
            if (abort && state != IDLE) begin
                // Cancel the run: no done pulse, and the error flag is left as it is
                state  <= IDLE;
                busy   <= 1'b0;
                mask_q <= '0;
                timer  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (go && !abort) begin
                            mask_q  <= enable_mask;
                            error   <= 1'b0;
                            err_idx <= '0;
                            busy    <= 1'b1;
                            if (|enable_mask) begin
                                active_idx  <= lowest(enable_mask);
                                child_start <= onehot(lowest(enable_mask));
                                state       <= LAUNCH;
                            end else begin
                                done  <= 1'b1;
                                state <= FINISH;
                            end
                        end
                    end
                    LAUNCH: begin
                        timer <= '0;
                        state <= WAIT;
                    end
                    WAIT: begin
                        // Done takes priority over timeout in the same cycle
                        if (child_done[active_idx]) begin
                            mask_q <= mask_rem;
                            if (|mask_rem) begin
                                active_idx  <= lowest(mask_rem);
                                child_start <= onehot(lowest(mask_rem));
                                state       <= LAUNCH;
                            end else begin
                                done  <= 1'b1;
                                state <= FINISH;
                            end
                        end else if (timer == TMR_LAST) begin
                            error   <= 1'b1;
                            err_idx <= active_idx;
                            mask_q  <= '0;
                            done    <= 1'b1;
                            state   <= FINISH;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    FINISH: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_child_launch_sequencer.sv
// tb_child_launch_sequencer: directed runs with hand-computed cycle expectations.
// Cycle numbers are counted from the edge that samples go; that edge is cycle 0.
module tb_child_launch_sequencer;

    localparam int NC    = 5;
    localparam int TMO   = 8;
    localparam int IDX_W = 3;
    localparam int DLY   = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             go = 1'b0;
    logic             abort = 1'b0;
    logic [NC-1:0]    enable_mask = '0;
    logic [NC-1:0]    child_start;
    logic [NC-1:0]    child_done = '0;
    logic             busy, done, error;
    logic [IDX_W-1:0] err_idx, active_idx;

    child_launch_sequencer #(.NUM_CHILD(NC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .enable_mask(enable_mask),
        .child_start(child_start), .child_done(child_done), .busy(busy), .done(done),
        .error(error), .err_idx(err_idx), .active_idx(active_idx)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int base = 0;
    int rel = 0;
    int busy_n = 0;
    int start_at [NC];
    logic [NC-1:0] resp_en = '1;
    int st_id[$];
    int st_rel[$];
    int st_idx[$];
    int done_rel[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock: sample outputs 1ns after the edge, log events, then drive the child responders
    task automatic tick();
        logic [NC-1:0] cd;
        @(posedge clk);
        #1;
        cyc++;
        rel = cyc - base;
        for (int i = 0; i < NC; i++)
            if (child_start[i]) begin
                st_id.push_back(i);
                st_rel.push_back(rel);
                st_idx.push_back(int'(active_idx));
                start_at[i] = cyc;
            end
        if (done) done_rel.push_back(rel);
        if (busy) busy_n++;
        cd = '0;
        for (int i = 0; i < NC; i++)
            cd[i] = resp_en[i] && (cyc == start_at[i] + DLY);
        child_done = cd;
    endtask

    task automatic go_pulse(input logic [NC-1:0] m);
        st_id.delete(); st_rel.delete(); st_idx.delete(); done_rel.delete();
        busy_n = 0;
        base = cyc;
        enable_mask = m;
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        for (int k = 0; k < bound && busy; k++) tick();
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic chk_start(input string tag, input int n, input int id, input int r);
        if (n < st_id.size()) begin
            chk({tag, "_id"}, st_id[n], id);
            chk({tag, "_rel"}, st_rel[n], r);
            chk({tag, "_aidx"}, st_idx[n], id);
        end else begin
            chk({tag, "_missing"}, 32'hFFFF_FFFF, r);
        end
    endtask

    initial begin
        for (int i = 0; i < NC; i++) start_at[i] = -100;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", error, 0);
        chk("rst_start", child_start, 0);
        chk("rst_aidx", active_idx, 0);
        #9 rst_n = 1'b1;
        tick(); tick();

        // All five children, each answering 3 cycles after its start
        go_pulse(5'b11111);
        chk("t1_busy1", busy, 1);
        wait_idle("t1", 40);
        chk("t1_nstart", st_id.size(), 5);
        for (int i = 0; i < 5; i++) chk_start("t1_s", i, i, 1 + 4 * i);
        chk("t1_ndone", done_rel.size(), 1);
        if (done_rel.size() > 0) chk("t1_done_rel", done_rel[0], 21);
        chk("t1_busy_n", busy_n, 21);
        chk("t1_err", error, 0);

        // Sparse mask
        go_pulse(5'b10100);
        wait_idle("t2", 30);
        chk("t2_nstart", st_id.size(), 2);
        chk_start("t2_s0", 0, 2, 1);
        chk_start("t2_s1", 1, 4, 5);
        if (done_rel.size() > 0) chk("t2_done_rel", done_rel[0], 9);
        else chk("t2_done_missing", 0, 1);

        // Empty mask goes straight to FINISH
        go_pulse(5'b00000);
        chk("t3_busy", busy, 1);
        chk("t3_done", done, 1);
        tick();
        chk("t3_busy2", busy, 0);
        chk("t3_nstart", st_id.size(), 0);

        // Child 1 never answers: timeout after 8 WAIT cycles
        resp_en = 5'b11101;
        go_pulse(5'b00011);
        wait_idle("t4", 40);
        resp_en = '1;
        chk("t4_nstart", st_id.size(), 2);
        chk_start("t4_s1", 1, 1, 5);
        chk("t4_ndone", done_rel.size(), 1);
        if (done_rel.size() > 0) chk("t4_done_rel", done_rel[0], 14);
        tick(); tick();
        chk("t4_err", error, 1);
        chk("t4_erridx", err_idx, 1);
        go_pulse(5'b00001);
        chk("t4_errclr", error, 0);
        chk("t4_erridx_clr", err_idx, 0);
        wait_idle("t4b", 20);

        // Abort while waiting on child 2
        go_pulse(5'b11111);
        while (rel < 10 && cyc < 5000) tick();
        chk("t5_aidx", active_idx, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        for (int k = 0; k < 4; k++) tick();
        chk("t5_nstart", st_id.size(), 3);
        chk("t5_ndone", done_rel.size(), 0);
        go_pulse(5'b00110);
        chk_start("t5_restart", 0, 1, 1);
        wait_idle("t5b", 30);

        // Asynchronous reset in WAIT, then go while busy is ignored
        go_pulse(5'b11111);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_aidx", active_idx, 0);
        chk("t6_start", child_start, 0);
        #3 rst_n = 1'b1;
        st_id.delete();
        for (int k = 0; k < 5; k++) tick();
        chk("t6_nostart", st_id.size(), 0);
        go_pulse(5'b00001);
        tick();
        enable_mask = 5'b11111;
        go = 1'b1;
        tick();
        go = 1'b0;
        wait_idle("t6", 30);
        chk("t6_nstart2", st_id.size(), 1);
        if (done_rel.size() > 0) chk("t6_done_rel", done_rel[0], 5);
        else chk("t6_done_missing", 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
